cache_fill_arbiter: RTL and testbench

- Sits between the I-cache/D-cache tag-data arrays and the single shared multi-cycle main memory.
- Arbitrates I-miss, D-miss and write-through store requests onto one memory port.
- On a miss, fills the 8-word block and writes the tag, then releases the stall signals that the CPU pipeline and bench use to qualify cache hit and request counts.

---
 rtl/cache_fill_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// cache_fill_arbiter: shares one multi-cycle memory port between I/D cache block
// fills and write-through stores, then writes the tag and releases the stalls.
module cache_fill_arbiter #(
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4,
  localparam int OFS    = $clog2(WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_miss,
  input  logic [15:0]    i_addr,
  input  logic           d_miss,
  input  logic [15:0]    d_addr,
  input  logic           d_store,
  input  logic [15:0]    d_st_addr,
  input  logic [15:0]    d_st_data,
  input  logic [15:0]    mem_rdata,
  input  logic           mem_valid,
  output logic           mem_en,
  output logic           mem_wr,
  output logic [15:0]    mem_addr,
  output logic [15:0]    mem_wdata,
  output logic           fill_we_i,
  output logic           fill_we_d,
  output logic [OFS-1:0] fill_word,
  output logic [15:0]    fill_data,
  output logic           tag_we_i,
  output logic           tag_we_d,
  output logic [15:0]    fill_base,
  output logic           i_stall,
  output logic           d_stall,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_D = 2'd1,
    FILL_I = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_D    = 2'd1,
    T_I    = 2'd2
  } target_t;

  localparam int            CW         = OFS + 1;
  localparam int            DW         = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] WORDS_C    = CW'(WORDS);
  localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);
  localparam logic [15:0]   BASE_MASK  = ~16'((1 << (OFS + 1)) - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(MEM_LAT);

  state_t        st;
  target_t       target;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] recv_cnt;
  logic [15:0]   base_q;
  logic          tag_i_q;
  logic          tag_d_q;
  logic [DW-1:0] drain;

  logic in_fill;
  logic issuing;
  logic accept;
  logic store_go;
  logic done_i;
  logic done_d;

  always_comb begin
    in_fill  = (st == FILL_D) || (st == FILL_I);
    issuing  = !rst && in_fill && (issue_cnt < WORDS_C);
    // Reads issued before a reset may still answer; drain masks them out.
    accept   = !rst && in_fill && mem_valid && (drain == '0) && (recv_cnt < WORDS_C);
    store_go = !rst && (st == IDLE) && d_store;

    mem_en    = issuing || store_go;
    mem_wr    = store_go;
    mem_addr  = '0;
    mem_wdata = '0;
    if (store_go) begin
      mem_addr  = d_st_addr;
      mem_wdata = d_st_data;
    end else if (issuing) begin
      mem_addr = base_q + 16'({issue_cnt, 1'b0});
    end

    fill_we_d = accept && (st == FILL_D);
    fill_we_i = accept && (st == FILL_I);
    fill_word = '0;
    fill_data = '0;
    if (accept) begin
      fill_word = recv_cnt[OFS-1:0];
      fill_data = mem_rdata;
    end

    done_i  = (st == DONE) && (target == T_I);
    done_d  = (st == DONE) && (target == T_D);
    i_stall = !rst && i_miss && !done_i;
    d_stall = !rst && d_miss && !done_d;
  end

  assign tag_we_i  = tag_i_q && !rst;
  assign tag_we_d  = tag_d_q && !rst;
  assign fill_base = base_q;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      target    <= T_NONE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base_q    <= '0;
      tag_i_q   <= 1'b0;
      tag_d_q   <= 1'b0;
      drain     <= DRAIN_INIT;
    end else begin
      tag_i_q <= 1'b0;
      tag_d_q <= 1'b0;
      if (drain != '0) drain <= drain - 1'b1;

      unique case (st)
        IDLE: begin
          // A store owns the port this cycle; any miss is taken next cycle.
          if (!d_store) begin
            if (d_miss) begin
              base_q <= d_addr & BASE_MASK;
              target <= T_D;
              st     <= FILL_D;
            end else if (i_miss) begin
              base_q <= i_addr & BASE_MASK;
              target <= T_I;
              st     <= FILL_I;
            end
          end
        end
        FILL_D, FILL_I: begin
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (accept) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST_WORD) begin
              st      <= DONE;
              tag_d_q <= (st == FILL_D);
              tag_i_q <= (st == FILL_I);
            end
          end
        end
        DONE: begin
          st        <= IDLE;
          target    <= T_NONE;
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// tb_cache_fill_arbiter: directed and randomized miss/store scenarios checked against
// a cycle schedule of block fills derived from issue order and memory latency.
module tb_cache_fill_arbiter;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int WB = 4;
  localparam int LB = 1;
  localparam int N  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_miss, d_miss, d_store;
  logic [15:0] i_addr, d_addr, d_st_addr, d_st_data;
  logic        mem_valid, mem_valid_b;
  logic [15:0] mem_rdata, mem_rdata_b;

  logic        mem_en, mem_wr, fill_we_i, fill_we_d, tag_we_i, tag_we_d, i_stall, d_stall;
  logic [15:0] mem_addr, mem_wdata, fill_data, fill_base;
  logic [2:0]  fill_word;
  logic [1:0]  state;

  logic        mem_en_b, mem_wr_b, fill_we_i_b, fill_we_d_b, tag_we_i_b, tag_we_d_b;
  logic        i_stall_b, d_stall_b;
  logic [15:0] mem_addr_b, mem_wdata_b, fill_data_b, fill_base_b;
  logic [1:0]  fill_word_b;
  logic [1:0]  state_b;

  cache_fill_arbiter #(.WORDS(W), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
    .d_store(d_store), .d_st_addr(d_st_addr), .d_st_data(d_st_data),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .fill_word(fill_word), .fill_data(fill_data), .tag_we_i(tag_we_i), .tag_we_d(tag_we_d),
    .fill_base(fill_base), .i_stall(i_stall), .d_stall(d_stall), .state(state)
  );

  cache_fill_arbiter #(.WORDS(WB), .MEM_LAT(LB)) dut_s (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
    .d_store(d_store), .d_st_addr(d_st_addr), .d_st_data(d_st_data),
    .mem_rdata(mem_rdata_b), .mem_valid(mem_valid_b), .mem_en(mem_en_b), .mem_wr(mem_wr_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .fill_we_i(fill_we_i_b),
    .fill_we_d(fill_we_d_b), .fill_word(fill_word_b), .fill_data(fill_data_b),
    .tag_we_i(tag_we_i_b), .tag_we_d(tag_we_d_b), .fill_base(fill_base_b),
    .i_stall(i_stall_b), .d_stall(d_stall_b), .state(state_b)
  );

  int total, bad;
  logic [15:0] salt;

  // Input schedule for one scenario
  logic        s_rst[N], s_im[N], s_dm[N], s_st[N], s_stray[N];
  logic [15:0] s_ia[N], s_da[N];
  logic [15:0] s_sa, s_sd;

  // Expected and observed per-cycle outputs, main instance
  logic [1:0]  e_st[N],   g_st[N];
  logic [33:0] e_mem[N],  g_mem[N];
  logic [20:0] e_fill[N], g_fill[N];
  logic [17:0] e_tag[N],  g_tag[N];
  logic        e_is[N], g_is[N], e_ds[N], g_ds[N], e_di[N], e_dd[N];

  // Expected and observed per-cycle outputs, small instance
  logic [1:0]  eb_st[N],   gb_st[N];
  logic [33:0] eb_mem[N],  gb_mem[N];
  logic [19:0] eb_fill[N], gb_fill[N];
  logic [17:0] eb_tag[N],  gb_tag[N];
  logic        eb_is[N], gb_is[N], gb_ds[N];

  // Memory read pipelines (fixed latency)
  logic        pa_v[L], pb_v[LB];
  logic [15:0] pa_a[L], pb_a[LB];

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ salt;
  endfunction

  task automatic chk(input string tag, input int c, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < N; c++) begin
      s_rst[c] = 0; s_im[c] = 0; s_dm[c] = 0; s_st[c] = 0; s_stray[c] = 0;
      s_ia[c] = '0; s_da[c] = '0;
      e_st[c] = '0; e_mem[c] = '0; e_fill[c] = '0; e_tag[c] = '0;
      e_is[c] = 0; e_ds[c] = 0; e_di[c] = 0; e_dd[c] = 0;
      eb_st[c] = '0; eb_mem[c] = '0; eb_fill[c] = '0; eb_tag[c] = '0; eb_is[c] = 0;
    end
    s_sa = '0; s_sd = '0;
  endtask

  // Block fill decided in IDLE at t0: reads t0+1.., data L later, tag at t0+W+L+1.
  // Events at or after a reset cycle 'cut' never happen.
  task automatic exp_fill(input int t0, input logic [15:0] addr, input logic is_i, input int cut);
    logic [15:0] base;
    int dn;
    base = addr & 16'hFFF0;
    dn   = t0 + W + L + 1;
    for (int k = 0; k < W; k++) begin
      if (t0 + 1 + k < cut) e_mem[t0 + 1 + k] = {1'b1, 1'b0, 16'(base + 2 * k), 16'h0000};
      if (t0 + 1 + L + k < cut)
        e_fill[t0 + 1 + L + k] = {is_i, !is_i, 3'(k), memfn(16'(base + 2 * k))};
    end
    for (int c = t0 + 1; c < dn && c <= cut; c++) e_st[c] = is_i ? 2'd2 : 2'd1;
    if (dn < cut) begin
      e_st[dn]  = 2'd3;
      e_tag[dn] = {is_i, !is_i, base};
      if (is_i) e_di[dn] = 1'b1;
      else e_dd[dn] = 1'b1;
    end
  endtask

  task automatic finish_exp();
    for (int c = 0; c < N; c++) begin
      e_is[c] = s_im[c] && !s_rst[c] && !e_di[c];
      e_ds[c] = s_dm[c] && !s_rst[c] && !e_dd[c];
    end
  endtask

  task automatic run(input int n);
    logic        ra_v, rb_v;
    logic [15:0] ra_a, rb_a;
    for (int c = 0; c < n; c++) begin
      rst = s_rst[c]; i_miss = s_im[c]; i_addr = s_ia[c];
      d_miss = s_dm[c]; d_addr = s_da[c]; d_store = s_st[c];
      d_st_addr = s_sa; d_st_data = s_sd;
      mem_valid = pa_v[L-1] | s_stray[c];
      mem_rdata = pa_v[L-1] ? memfn(pa_a[L-1]) : (s_stray[c] ? 16'($urandom) : 16'h0000);
      mem_valid_b = pb_v[LB-1];
      mem_rdata_b = pb_v[LB-1] ? memfn(pb_a[LB-1]) : 16'h0000;
      @(negedge clk);
      g_st[c]   = state;
      g_mem[c]  = {mem_en, mem_wr, mem_addr, mem_wdata};
      g_fill[c] = {fill_we_i, fill_we_d, fill_word, fill_data};
      g_tag[c]  = {tag_we_i, tag_we_d, (tag_we_i | tag_we_d) ? fill_base : 16'h0000};
      g_is[c] = i_stall; g_ds[c] = d_stall;
      gb_st[c]   = state_b;
      gb_mem[c]  = {mem_en_b, mem_wr_b, mem_addr_b, mem_wdata_b};
      gb_fill[c] = {fill_we_i_b, fill_we_d_b, fill_word_b, fill_data_b};
      gb_tag[c]  = {tag_we_i_b, tag_we_d_b, (tag_we_i_b | tag_we_d_b) ? fill_base_b : 16'h0000};
      gb_is[c] = i_stall_b; gb_ds[c] = d_stall_b;
      ra_v = mem_en & !mem_wr;     ra_a = mem_addr;
      rb_v = mem_en_b & !mem_wr_b; rb_a = mem_addr_b;
      @(posedge clk);
      #1;
      for (int k = L - 1; k > 0; k--) begin pa_v[k] = pa_v[k-1]; pa_a[k] = pa_a[k-1]; end
      pa_v[0] = ra_v; pa_a[0] = ra_a;
      for (int k = LB - 1; k > 0; k--) begin pb_v[k] = pb_v[k-1]; pb_a[k] = pb_a[k-1]; end
      pb_v[0] = rb_v; pb_a[0] = rb_a;
    end
  endtask

  task automatic reset_dut();
    clear_sched();
    for (int c = 0; c < 6; c++) s_rst[c] = 1'b1;
    run(6);
    clear_sched();
  endtask

  task automatic check_a(input string nm, input int n);
    for (int c = 0; c < n; c++) begin
      chk({nm, ".state"},  c, 64'(g_st[c]),   64'(e_st[c]));
      chk({nm, ".mem"},    c, 64'(g_mem[c]),  64'(e_mem[c]));
      chk({nm, ".fill"},   c, 64'(g_fill[c]), 64'(e_fill[c]));
      chk({nm, ".tag"},    c, 64'(g_tag[c]),  64'(e_tag[c]));
      chk({nm, ".istall"}, c, 64'(g_is[c]),   64'(e_is[c]));
      chk({nm, ".dstall"}, c, 64'(g_ds[c]),   64'(e_ds[c]));
    end
  endtask

  task automatic check_b(input string nm, input int n);
    for (int c = 0; c < n; c++) begin
      chk({nm, ".state"},  c, 64'(gb_st[c]),   64'(eb_st[c]));
      chk({nm, ".mem"},    c, 64'(gb_mem[c]),  64'(eb_mem[c]));
      chk({nm, ".fill"},   c, 64'(gb_fill[c]), 64'(eb_fill[c]));
      chk({nm, ".tag"},    c, 64'(gb_tag[c]),  64'(eb_tag[c]));
      chk({nm, ".istall"}, c, 64'(gb_is[c]),   64'(eb_is[c]));
      chk({nm, ".dstall"}, c, 64'(gb_ds[c]),   64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    salt = 16'($urandom);
    rst = 1'b1; i_miss = 0; d_miss = 0; d_store = 0;
    i_addr = '0; d_addr = '0; d_st_addr = '0; d_st_data = '0;
    mem_valid = 0; mem_valid_b = 0; mem_rdata = '0; mem_rdata_b = '0;
    for (int k = 0; k < L; k++) begin pa_v[k] = 0; pa_a[k] = '0; end
    for (int k = 0; k < LB; k++) begin pb_v[k] = 0; pb_a[k] = '0; end

    for (int r = 0; r < 4; r++) begin
      logic [15:0] a, ia, da;
      logic        is_i;
      int          t0, nw;

      // Single miss, stall held until the DONE cycle
      a    = (r == 0) ? 16'h0124 : 16'($urandom);
      is_i = (r == 0) ? 1'b1 : 1'($urandom);
      t0   = (r == 0) ? 0 : int'($urandom_range(0, 3));
      reset_dut();
      for (int c = 0; c < N; c++) begin s_ia[c] = a; s_da[c] = a; end
      for (int c = t0; c <= t0 + W + L + 1; c++) begin
        if (is_i) s_im[c] = 1'b1;
        else s_dm[c] = 1'b1;
      end
      exp_fill(t0, a, is_i, N);
      finish_exp();
      run(t0 + 16);
      check_a("single", t0 + 16);

      // D and I miss together: D first, I from the IDLE after D's DONE
      da = (r == 0) ? 16'h4008 : 16'($urandom);
      ia = (r == 0) ? 16'h0000 : 16'($urandom);
      reset_dut();
      for (int c = 0; c < N; c++) begin s_ia[c] = ia; s_da[c] = da; end
      for (int c = 0; c <= 13; c++) s_dm[c] = 1'b1;
      for (int c = 0; c <= 27; c++) s_im[c] = 1'b1;
      exp_fill(0, da, 1'b0, N);
      exp_fill(14, ia, 1'b1, N);
      finish_exp();
      run(30);
      check_a("both", 30);

      // Write-through store beside an I miss
      ia   = (r == 0) ? 16'h3456 : 16'($urandom);
      s_sa = (r == 0) ? 16'h2002 : 16'($urandom);
      s_sd = (r == 0) ? 16'hBEEF : 16'($urandom);
      reset_dut();
      s_sa = (r == 0) ? 16'h2002 : 16'($urandom);
      s_sd = (r == 0) ? 16'hBEEF : 16'($urandom);
      for (int c = 0; c < N; c++) s_ia[c] = ia;
      s_st[0] = 1'b1;
      for (int c = 0; c <= 14; c++) s_im[c] = 1'b1;
      e_mem[0] = {1'b1, 1'b1, s_sa, s_sd};
      exp_fill(1, ia, 1'b1, N);
      finish_exp();
      run(18);
      check_a("store", 18);
      nw = 0;
      for (int c = 0; c < 18; c++) nw += int'(g_mem[c][33] & g_mem[c][32]);
      chk("store.writes", 0, 64'(nw), 64'd1);
    end

    begin
      logic [15:0] da0, da1, ia;

      // Reset during a D fill, then a fresh D fill while old reads still answer
      da0 = 16'($urandom);
      da1 = 16'($urandom);
      reset_dut();
      for (int c = 0; c <= 5; c++) begin s_dm[c] = 1'b1; s_da[c] = da0; end
      s_rst[6] = 1'b1;
      s_stray[7] = 1'b1;
      for (int c = 8; c <= 21; c++) begin s_dm[c] = 1'b1; s_da[c] = da1; end
      exp_fill(0, da0, 1'b0, 6);
      exp_fill(8, da1, 1'b0, N);
      finish_exp();
      run(24);
      check_a("rstfill", 24);

      // Spurious responses in IDLE leave the counters at zero
      ia = 16'($urandom);
      reset_dut();
      s_stray[1] = 1'b1; s_stray[4] = 1'b1; s_stray[5] = 1'b1;
      for (int c = 0; c < N; c++) s_ia[c] = ia;
      for (int c = 6; c <= 19; c++) s_im[c] = 1'b1;
      exp_fill(6, ia, 1'b1, N);
      finish_exp();
      run(22);
      check_a("spurious", 22);

      // Small configuration: WORDS=4, MEM_LAT=1 -> DONE at cycle 6
      ia = 16'($urandom);
      reset_dut();
      for (int c = 0; c < N; c++) s_ia[c] = ia;
      for (int c = 0; c <= 6; c++) s_im[c] = 1'b1;
      for (int k = 0; k < WB; k++) begin
        eb_mem[1 + k] = {1'b1, 1'b0, 16'((ia & 16'hFFF8) + 2 * k), 16'h0000};
        eb_fill[1 + LB + k] = {1'b1, 1'b0, 2'(k), memfn(16'((ia & 16'hFFF8) + 2 * k))};
      end
      for (int c = 1; c <= 5; c++) eb_st[c] = 2'd2;
      eb_st[6]  = 2'd3;
      eb_tag[6] = {1'b1, 1'b0, ia & 16'hFFF8};
      for (int c = 0; c <= 5; c++) eb_is[c] = 1'b1;
      run(8);
      check_b("small", 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
